display_select: RTL and testbench
=================================

# display_select

Parametrised front-panel output block for the Blueberry Pi core. It drives the bus LED bar from source 0 and the seven-segment readout for `NSRC` selectable data sources (bus, registers, ALU and so on). The displayed source steps on each debounced press of the Peek pushbutton. A freeze input holds a snapshot on the display, and the done LED blinks when execution completes. It sits between the datapath and the board pins, replacing the single-bus/single-register display stage with a clocked, debounced, N-source version.

## Interface
Parameters:
- `WIDTH`, default 10: data width of each source.
- `NSRC`, default 2: number of selectable sources, ≥1.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive stable synchronised samples required to accept a button level, ≥1.
- `BLINK_CYCLES`, default 4: half-period of the done blink, in clocks, ≥1.

Derived constants:
- `NDIG` = (WIDTH+3)/4.
- `SELW` = max(1, $clog2(NSRC)).

Ports:
- `Clk`, input, 1: the single clock; all state is rising-edge.
- `Resetn`, input, 1: asynchronous, active-low reset.
- `Src`, input, NSRC*WIDTH: source k is `Src[k*WIDTH +: WIDTH]`.
- `Time`, input, 2: step counter, shown on `THEX`.
- `Peekb`, input, 1: asynchronous, active-low pushbutton; 0 = pressed.
- `Freeze`, input, 1: synchronous level; 1 = hold the display.
- `done`, input, 1: synchronous level; program finished.
- `Led_B`, output, WIDTH: equals source 0, combinational.
- `DHEX`, output, NDIG*7: digit d is `DHEX[d*7 +: 7]`; d=0 is the least-significant nibble.
- `THEX`, output, 7: `Time` glyph.
- `Sel`, output, SELW: index of the source currently selected.
- `Frozen`, output, 1: display is showing the snapshot.
- `Led_D`, output, 1: done indicator.

## Operation
- Segment encoding:
  - Outputs are active-low, with bit0=a … bit6=g.
  - Glyphs are the standard hex set 0–F. Examples: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 5=7'b0010010, A=7'b0001000, F=7'b0001110.
- Digit sources:
  - Digit d shows nibble d of the display value.
  - The top digit is zero-extended when WIDTH is not a multiple of 4.
  - `THEX` shows {2'b00, Time}.
- Button path:
  - `Peekb` passes through a 2-flop synchroniser to give `pb_s`.
  - The debounce counter increments on each cycle where `pb_s` ≠ `stable`. It clears to 0 on any cycle where `pb_s` = `stable`.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, `stable` ← `pb_s` and the counter clears.
  - A press event is a `stable` transition from 1 to 0. A release event does nothing.
- Selection:
  - On a press event, `Sel` ← (Sel == NSRC-1) ? 0 : Sel+1.
  - When NSRC=1, `Sel` stays 0.
- Freeze:
  - On an edge with Freeze=1 and Frozen=0: `snap` ← Src[Sel] (the live value), and `Frozen` ← 1.
  - On an edge with Freeze=0: `Frozen` ← 0.
  - Display value = Frozen ? snap : Src[Sel].
  - Press events still advance `Sel` while frozen. The display switches to the new source only after unfreeze.
- Done LED:
  - When done=0: Led_D=1, and the blink counter and phase clear.
  - When done=1: the counter counts 0..BLINK_CYCLES-1 and wraps. Phase toggles on each wrap. Led_D = phase.
  - Phase is 0 on the first done=1 cycle, so the LED starts off, matching the previous "off when done" behaviour.
- Reset values (asynchronous, immediate):
  - Synchroniser flops = 1, `stable` = 1, debounce counter = 0.
  - `Sel` = 0, `Frozen` = 0, `snap` = 0, blink counter and phase = 0.
  - Outputs during reset: `DHEX` shows Src[0], `Led_D` = ~done, `Led_B` = Src[0].

## Timing
- `Led_B`, `DHEX`, `THEX`: combinational from inputs and registers; no added latency.
- Button latency: take edge E0 as the first edge that samples Peekb=0.
  - `pb_s` is 0 after E1.
  - `Sel` updates at edge E1+DEBOUNCE_CYCLES. With the default of 4, that is E5.
- Bounce: any return of `pb_s` to the `stable` level before the count completes restarts the count. No event is generated.
- A held button generates exactly one event. The release must also be stable for DEBOUNCE_CYCLES before the next press can count.
- Freeze: a capture on edge E shows `snap` from just after E. Src changes at edge E itself are not captured.
- Simultaneous press event and Freeze rising edge at the same edge: `snap` captures the pre-increment source. `Sel` still increments.
- Reset asserted mid-debounce or mid-blink: all state returns to reset values. Counting restarts after deassertion.

## Test plan
- Reset with WIDTH=10, Src0=10'h2A5: DHEX0=5 glyph (0010010), DHEX1=A (0001000), DHEX2=2 (0100100); Sel=0; Frozen=0.
- Peekb held low 10 cycles, DEBOUNCE_CYCLES=4: Sel 0→1 exactly at E5; no second increment. Release, then press again: Sel wraps 1→0 (NSRC=2).
- Bounce: Peekb low 2 cycles, high 1, low 2, then high: Sel unchanged. Then hold low ≥6 cycles: one increment.
- Freeze=1 with Src[Sel]=10'h3FF; change the source to 10'h000: DHEX stays F/F/3 and Frozen=1. Freeze=0: display shows 0/0/0 on the next cycle.
- done 0→1 with BLINK_CYCLES=4: Led_D=1 before; then 0 for 4 cycles, 1 for 4, 0 for 4. done→0: Led_D=1 immediately; counter cleared.
- NSRC=3, WIDTH=6, Src2=6'h3C: three presses cycle Sel 1,2,0. At Sel=2: DHEX0=C, DHEX1=3 (0110000). Resetn pulsed mid-debounce: Sel=0 and no event afterward.

Source files
------------

// File: rtl/display_select.sv
// Front-panel output stage: LED bar, N-source seven-segment readout stepped by a debounced
// Peek button, freeze-frame snapshot and a blinking done LED.
module display_select #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned NSRC            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_CYCLES    = 4
) (
  input  logic                                           Clk,
  input  logic                                           Resetn,
  input  logic [NSRC*WIDTH-1:0]                          Src,
  input  logic [1:0]                                     Time,
  input  logic                                           Peekb,
  input  logic                                           Freeze,
  input  logic                                           done,
  output logic [WIDTH-1:0]                               Led_B,
  output logic [((WIDTH+3)/4)*7-1:0]                     DHEX,
  output logic [6:0]                                     THEX,
  output logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0]     Sel,
  output logic                                           Frozen,
  output logic                                           Led_D
);

  localparam int unsigned NDIG = (WIDTH + 3) / 4;
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BLW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  logic             sync_q, pb_s_q;
  logic             stable_q, stable_d;
  logic [DBW-1:0]   db_cnt_q, db_cnt_d;
  logic             press;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             frozen_q, frozen_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [BLW-1:0]   blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] live, disp;
  logic [NDIG*4-1:0] padded;

  // Debounce: count consecutive cycles disagreeing with the accepted level.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (pb_s_q != stable_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = pb_s_q;
        press    = ~pb_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (press) begin
      sel_d = (sel_q == SELW'(NSRC - 1)) ? '0 : sel_q + SELW'(1);
    end
  end

  assign live = Src[32'(sel_q) * WIDTH +: WIDTH];

  // Capture uses the pre-increment selection, even on a simultaneous press.
  always_comb begin
    snap_d   = snap_q;
    frozen_d = frozen_q;
    if (Freeze && !frozen_q) begin
      snap_d   = live;
      frozen_d = 1'b1;
    end else if (!Freeze) begin
      frozen_d = 1'b0;
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (done) begin
      phase_d = phase_q;
      if (blink_cnt_q == BLW'(BLINK_CYCLES - 1)) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sync_q      <= 1'b1;
      pb_s_q      <= 1'b1;
      stable_q    <= 1'b1;
      db_cnt_q    <= '0;
      sel_q       <= '0;
      frozen_q    <= 1'b0;
      snap_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      sync_q      <= Peekb;
      pb_s_q      <= sync_q;
      stable_q    <= stable_d;
      db_cnt_q    <= db_cnt_d;
      sel_q       <= sel_d;
      frozen_q    <= frozen_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign disp = frozen_q ? snap_q : live;

  always_comb begin
    padded            = '0;
    padded[WIDTH-1:0] = disp;
  end

  for (genvar d = 0; d < NDIG; d++) begin : g_digit
    assign DHEX[d*7 +: 7] = seg7(padded[d*4 +: 4]);
  end

  assign THEX   = seg7({2'b00, Time});
  assign Led_B  = Src[WIDTH-1:0];
  assign Sel    = sel_q;
  assign Frozen = frozen_q;
  assign Led_D  = done ? phase_q : 1'b1;

endmodule

// File: tb/tb_display_select.sv
// Directed bench for display_select: one 10-bit/2-source instance and one 6-bit/3-source
// instance, with expectations queued at drive time and checked on sampling.
module tb_display_select;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance A: WIDTH=10, NSRC=2
  logic        rst_a_n, peekb_a, freeze_a, done_a;
  logic [9:0]  src_a0, src_a1;
  logic [1:0]  time_a;
  logic [9:0]  led_b_a;
  logic [20:0] dhex_a;
  logic [6:0]  thex_a;
  logic        sel_a, frozen_a, led_d_a;

  display_select #(
    .WIDTH(10), .NSRC(2), .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(4)
  ) u_a (
    .Clk(clk), .Resetn(rst_a_n), .Src({src_a1, src_a0}), .Time(time_a), .Peekb(peekb_a),
    .Freeze(freeze_a), .done(done_a), .Led_B(led_b_a), .DHEX(dhex_a), .THEX(thex_a),
    .Sel(sel_a), .Frozen(frozen_a), .Led_D(led_d_a)
  );

  // Instance B: WIDTH=6, NSRC=3
  logic        rst_b_n, peekb_b, freeze_b, done_b;
  logic [5:0]  src_b0, src_b1, src_b2;
  logic [1:0]  time_b;
  logic [5:0]  led_b_b;
  logic [13:0] dhex_b;
  logic [6:0]  thex_b;
  logic [1:0]  sel_b;
  logic        frozen_b, led_d_b;

  display_select #(
    .WIDTH(6), .NSRC(3), .DEBOUNCE_CYCLES(4), .BLINK_CYCLES(4)
  ) u_b (
    .Clk(clk), .Resetn(rst_b_n), .Src({src_b2, src_b1, src_b0}), .Time(time_b),
    .Peekb(peekb_b), .Freeze(freeze_b), .done(done_b), .Led_B(led_b_b), .DHEX(dhex_b),
    .THEX(thex_b), .Sel(sel_b), .Frozen(frozen_b), .Led_D(led_d_b)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } item_t;

  item_t sb[$];
  int    total  = 0;
  int    passed = 0;

  function automatic logic [6:0] g(input int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic push(input string tag, input logic [63:0] v);
    item_t it;
    it.tag = tag;
    it.val = v;
    sb.push_back(it);
  endtask

  task automatic observe(input logic [63:0] obs);
    item_t it;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.val) passed++;
      else $error("FAIL %s: observed %h expected %h", it.tag, obs, it.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_b();
    peekb_b = 1'b0;
    repeat (7) tick();
    peekb_b = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    rst_a_n = 1'b0; peekb_a = 1'b1; freeze_a = 1'b0; done_a = 1'b0;
    src_a0 = 10'h2A5; src_a1 = 10'h3FF; time_a = 2'b11;
    rst_b_n = 1'b0; peekb_b = 1'b1; freeze_b = 1'b0; done_b = 1'b0;
    src_b0 = 6'h11; src_b1 = 6'h22; src_b2 = 6'h3C; time_b = 2'b01;
    #2;

    push("rst_dhex_a", 64'({g(2), g(10), g(5)}));   observe(64'(dhex_a));
    push("rst_sel_a", 64'(0));                       observe(64'(sel_a));
    push("rst_frozen_a", 64'(0));                    observe(64'(frozen_a));
    push("rst_led_d_a", 64'(1));                     observe(64'(led_d_a));
    push("rst_led_b_a", 64'(10'h2A5));               observe(64'(led_b_a));
    push("thex_a", 64'(7'b0110000));                 observe(64'(thex_a));
    push("thex_b", 64'(7'b1111001));                 observe(64'(thex_b));
    push("rst_dhex_b", 64'({g(1), g(1)}));           observe(64'(dhex_b));

    tick(); tick();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (3) tick();

    // Held press: one increment, exactly at E5
    peekb_a = 1'b0;
    push("press_pre_e5", 64'(0));
    repeat (5) tick();
    observe(64'(sel_a));
    push("press_at_e5", 64'(1));
    tick();
    observe(64'(sel_a));
    push("held_no_repeat", 64'(1));
    repeat (5) tick();
    observe(64'(sel_a));
    peekb_a = 1'b1;
    repeat (8) tick();

    peekb_a = 1'b0;
    push("wrap_to_0", 64'(0));
    repeat (7) tick();
    observe(64'(sel_a));
    peekb_a = 1'b1;
    repeat (8) tick();

    // Bounce: 2 low, 1 high, 2 low, then high
    peekb_a = 1'b0; tick(); tick();
    peekb_a = 1'b1; tick();
    peekb_a = 1'b0; tick(); tick();
    peekb_a = 1'b1;
    push("bounce_no_event", 64'(0));
    repeat (8) tick();
    observe(64'(sel_a));
    peekb_a = 1'b0;
    push("after_bounce_press", 64'(1));
    repeat (7) tick();
    observe(64'(sel_a));
    peekb_a = 1'b1;
    repeat (8) tick();

    // Freeze on source 1 = 3FF, then change the source underneath
    freeze_a = 1'b1;
    push("frz_frozen", 64'(1));
    push("frz_dhex", 64'({g(3), g(15), g(15)}));
    tick();
    observe(64'(frozen_a));
    observe(64'(dhex_a));
    src_a1 = 10'h000;
    push("frz_hold_dhex", 64'({g(3), g(15), g(15)}));
    push("frz_hold_frozen", 64'(1));
    push("frz_led_b", 64'(10'h2A5));
    tick();
    observe(64'(dhex_a));
    observe(64'(frozen_a));
    observe(64'(led_b_a));
    freeze_a = 1'b0;
    push("unfrz_frozen", 64'(0));
    push("unfrz_dhex", 64'({g(0), g(0), g(0)}));
    tick();
    observe(64'(frozen_a));
    observe(64'(dhex_a));

    // Press event and Freeze rising on the same edge: snapshot is pre-increment source
    peekb_a = 1'b0;
    repeat (5) tick();
    freeze_a = 1'b1;
    push("simul_sel", 64'(0));
    push("simul_frozen", 64'(1));
    push("simul_snap", 64'({g(0), g(0), g(0)}));
    tick();
    observe(64'(sel_a));
    observe(64'(frozen_a));
    observe(64'(dhex_a));
    freeze_a = 1'b0;
    push("simul_after", 64'({g(2), g(10), g(5)}));
    tick();
    observe(64'(dhex_a));
    peekb_a = 1'b1;
    repeat (8) tick();

    // Done blink
    push("done_before", 64'(1));
    observe(64'(led_d_a));
    done_a = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      push($sformatf("blink_%0d", k), 64'(((k / 4) % 2 == 1) ? 1 : 0));
      observe(64'(led_d_a));
      tick();
    end
    done_a = 1'b0;
    #1;
    push("done_off", 64'(1));
    observe(64'(led_d_a));
    tick();
    done_a = 1'b1;
    #1;
    push("blink_restart_off", 64'(0));
    observe(64'(led_d_a));
    repeat (3) tick();
    push("blink_restart_still_off", 64'(0));
    observe(64'(led_d_a));
    tick();
    push("blink_restart_on", 64'(1));
    observe(64'(led_d_a));
    done_a = 1'b0;

    // Instance B: three-source cycling
    push("b_sel1", 64'(1));
    push("b_dhex_sel1", 64'({g(2), g(2)}));
    press_b();
    observe(64'(sel_b));
    observe(64'(dhex_b));
    push("b_sel2", 64'(2));
    push("b_dhex_sel2", 64'({7'b0110000, g(12)}));
    push("b_led_b", 64'(6'h11));
    press_b();
    observe(64'(sel_b));
    observe(64'(dhex_b));
    observe(64'(led_b_b));
    push("b_sel0", 64'(0));
    press_b();
    observe(64'(sel_b));
    push("b_sel1_again", 64'(1));
    press_b();
    observe(64'(sel_b));

    // Reset mid-debounce
    done_b  = 1'b1;
    peekb_b = 1'b0;
    repeat (3) tick();
    rst_b_n = 1'b0;
    peekb_b = 1'b1;
    #1;
    push("b_rst_sel", 64'(0));
    push("b_rst_led_d", 64'(0));
    push("b_rst_dhex", 64'({g(1), g(1)}));
    observe(64'(sel_b));
    observe(64'(led_d_b));
    observe(64'(dhex_b));
    tick();
    rst_b_n = 1'b1;
    push("b_no_event_after_rst", 64'(0));
    repeat (10) tick();
    observe(64'(sel_b));

    if (sb.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
